// File: rtl/rr_quota_arbiter_pkg.sv
// rtl/rr_quota_arbiter_pkg.sv - shared state encoding and width helper for the quota arbiter
package rr_quota_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_quota_arbiter_if.sv
// rtl/rr_quota_arbiter_if.sv - request/grant bundle between requesting masters and the arbiter
interface rr_quota_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  logic [N-1:0]    request;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            quota_expired;

  modport master (
    output request,
    input  grant, grant_valid, grant_id, quota_expired
  );

  modport slave (
    input  request,
    output grant, grant_valid, grant_id, quota_expired
  );
endinterface

// File: rtl/rr_quota_arbiter_pick.sv
// rtl/rr_quota_arbiter_pick.sv - round-robin winner search starting at a given index
module rr_quota_arbiter_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] start,
  output logic            found,
  output logic [ID_W-1:0] win_id,
  output logic [N-1:0]    win_onehot
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum_id;

  always_comb begin
    dbl = {mask, mask};
    // rot[i] corresponds to requester (start + i) mod N
    rot = dbl[start +: N];
    found = 1'b0;
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off = ID_W'(i);
      end
    end
    sum_id = {1'b0, start} + {1'b0, off};
    win_id = (sum_id >= (ID_W+1)'(N)) ? ID_W'(sum_id - (ID_W+1)'(N)) : ID_W'(sum_id);
    win_onehot = found ? ({{(N-1){1'b0}}, 1'b1} << win_id) : '0;
  end

endmodule

// File: rtl/rr_quota_arbiter.sv
// rtl/rr_quota_arbiter.sv - round-robin arbiter with per-owner hold quota and forced rotation
module rr_quota_arbiter
  import rr_quota_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = clog2(N),
  parameter int CNT_W    = clog2(MAX_HOLD + 1)
) (
  input  logic                clock,
  input  logic                reset,
  rr_quota_arbiter_if.slave   bus
);

  arb_state_e      state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [ID_W-1:0] last_id, last_nxt;
  logic [N-1:0]    grant_q, grant_nxt;
  logic [ID_W-1:0] grant_id_q, grant_id_nxt;
  logic            valid_q, valid_nxt;
  logic            expired_q, expired_nxt;

  logic [N-1:0]    cand;
  logic [ID_W-1:0] start;
  logic            own_req;
  logic            found;
  logic [ID_W-1:0] win_id;
  logic [N-1:0]    win_onehot;

  // In BUSY the owner is excluded; on voluntary release its bit is already low.
  assign cand    = (state == ST_BUSY) ? (bus.request & ~grant_q) : bus.request;
  assign own_req = |(bus.request & grant_q);
  assign start   = (last_id == ID_W'(N - 1)) ? '0 : last_id + 1'b1;

  rr_quota_arbiter_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .mask       (cand),
    .start      (start),
    .found      (found),
    .win_id     (win_id),
    .win_onehot (win_onehot)
  );

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    last_nxt    = last_id;
    grant_nxt   = grant_q;
    expired_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_BUSY;
          grant_nxt = win_onehot;
          hold_nxt  = CNT_W'(1);
          last_nxt  = win_id;
        end
      end
      ST_BUSY: begin
        if (!own_req) begin
          if (found) begin
            grant_nxt = win_onehot;
            hold_nxt  = CNT_W'(1);
            last_nxt  = win_id;
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt < CNT_W'(MAX_HOLD)) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end else if (found) begin
          grant_nxt   = win_onehot;
          hold_nxt    = CNT_W'(1);
          last_nxt    = win_id;
          expired_nxt = 1'b1;
        end else begin
          // nobody else waiting: owner keeps the resource with a fresh quota
          hold_nxt = CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    valid_nxt    = (state_nxt == ST_BUSY);
    grant_id_nxt = valid_nxt ? last_nxt : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      last_id    <= ID_W'(N - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      last_id    <= last_nxt;
      grant_q    <= grant_nxt;
      grant_id_q <= grant_id_nxt;
      valid_q    <= valid_nxt;
      expired_q  <= expired_nxt;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.grant_valid   = valid_q;
  assign bus.quota_expired = expired_q;

endmodule

// File: tb/tb_rr_quota_arbiter.sv
// tb/tb_rr_quota_arbiter.sv - self-checking bench for rr_quota_arbiter
module tb_rr_quota_arbiter;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;
  localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rr_quota_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();

  rr_quota_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 when idle), cycles held, last granted index.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = N - 1;
  bit m_exp   = 1'b0;

  function automatic int pick(input logic [N-1:0] r);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic rst);
    int w;
    logic [N-1:0] others;
    m_exp = 1'b0;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = N - 1;
    end else if (m_owner < 0 || !req[m_owner]) begin
      w = pick(req);
      if (w >= 0) begin
        m_owner = w; m_cnt = 1; m_last = w;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end else if (m_cnt < MAX_HOLD) begin
      m_cnt++;
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      w = pick(others);
      if (w >= 0) begin
        m_owner = w; m_cnt = 1; m_last = w; m_exp = 1'b1;
      end else begin
        m_cnt = 1;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic rst);
    bus.request = req;
    reset = rst;
    @(posedge clock);
    model_step(req, rst);
    #1;
  endtask

  task automatic test_reset();
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0
        || bus.quota_expired !== 1'b0) begin
      $display("FAIL reset: grant=%b valid=%b id=%0d exp=%b, required all zero",
               bus.grant, bus.grant_valid, bus.grant_id, bus.quota_expired);
      n_fail++;
    end
  endtask

  task automatic test_single_grant();
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0001, 1'b0);
      n_tests++;
      if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
        $display("FAIL single_grant c%0d: grant=%b valid=%b id=%0d, required 0001/1/0",
                 c, bus.grant, bus.grant_valid, bus.grant_id);
        n_fail++;
      end
    end
    cycle(4'b0000, 1'b0);
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin
      $display("FAIL single_release: grant=%b valid=%b id=%0d, required 0000/0/0",
               bus.grant, bus.grant_valid, bus.grant_id);
      n_fail++;
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g;
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b0);
    n_tests++;
    if (bus.grant !== 4'b0001) begin
      $display("FAIL rotation_first: grant=%b, required 0001", bus.grant);
      n_fail++;
    end
    for (int k = 0; k < N; k++) begin
      cycle(4'b1111, 1'b0);
      exp_g = 4'b0001 << k;
      n_tests++;
      if (bus.grant !== exp_g) begin
        $display("FAIL rotation_hold k%0d: grant=%b, required %b", k, bus.grant, exp_g);
        n_fail++;
      end
      cycle(4'b1111 & ~(4'b0001 << k), 1'b0);
      exp_g = 4'b0001 << ((k + 1) % N);
      n_tests++;
      if (bus.grant !== exp_g || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'((k + 1) % N)) begin
        $display("FAIL rotation_handoff k%0d: grant=%b valid=%b id=%0d, required %b/1/%0d",
                 k, bus.grant, bus.grant_valid, bus.grant_id, exp_g, (k + 1) % N);
        n_fail++;
      end
    end
  endtask

  task automatic test_quota_expiry();
    logic [N-1:0] exp_g;
    logic exp_q;
    cycle(4'b0000, 1'b1);
    for (int c = 0; c < 4 * MAX_HOLD; c++) begin
      cycle(4'b0011, 1'b0);
      exp_g = ((c / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
      exp_q = (c > 0) && (c % MAX_HOLD == 0);
      n_tests++;
      if (bus.grant !== exp_g || bus.quota_expired !== exp_q) begin
        $display("FAIL quota_expiry c%0d: grant=%b exp=%b, required %b/%b",
                 c, bus.grant, bus.quota_expired, exp_g, exp_q);
        n_fail++;
      end
    end
  endtask

  task automatic test_lone_owner();
    cycle(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0100, 1'b0);
      n_tests++;
      if (bus.grant !== 4'b0100 || bus.quota_expired !== 1'b0 || bus.grant_id !== 2'd2) begin
        $display("FAIL lone_owner c%0d: grant=%b exp=%b id=%0d, required 0100/0/2",
                 c, bus.grant, bus.quota_expired, bus.grant_id);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    cycle(4'b1000, 1'b0);
    n_tests++;
    if (bus.grant !== 4'b1000) begin
      $display("FAIL mid_grant_setup: grant=%b, required 1000", bus.grant);
      n_fail++;
    end
    cycle(4'b1111, 1'b1);
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0
        || bus.quota_expired !== 1'b0) begin
      $display("FAIL mid_grant_reset: grant=%b valid=%b id=%0d exp=%b, required all zero",
               bus.grant, bus.grant_valid, bus.grant_id, bus.quota_expired);
      n_fail++;
    end
    cycle(4'b1111, 1'b0);
    n_tests++;
    if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0 || bus.grant_valid !== 1'b1) begin
      $display("FAIL after_reset_first: grant=%b id=%0d valid=%b, required 0001/0/1",
               bus.grant, bus.grant_id, bus.grant_valid);
      n_fail++;
    end
  endtask

  task automatic test_random_stress();
    logic [N-1:0] rq;
    logic [N-1:0] exp_g;
    logic [ID_W-1:0] exp_id;
    logic rst;
    int waiting[N];
    int errs;
    errs = 0;
    rq = '0;
    for (int i = 0; i < N; i++) waiting[i] = 0;
    for (int c = 0; c < 10000 && errs < 40; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      rst = ($urandom_range(0, 999) == 0);
      cycle(rq, rst);
      exp_g  = (m_owner < 0) ? '0 : (4'b0001 << m_owner);
      exp_id = (m_owner < 0) ? '0 : ID_W'(m_owner);
      n_tests++;
      if (bus.grant !== exp_g || bus.grant_id !== exp_id || bus.quota_expired !== m_exp
          || bus.grant_valid !== (m_owner >= 0)) begin
        $display("FAIL random c%0d: grant=%b id=%0d exp=%b valid=%b, required %b/%0d/%b/%b",
                 c, bus.grant, bus.grant_id, bus.quota_expired, bus.grant_valid,
                 exp_g, exp_id, m_exp, (m_owner >= 0));
        n_fail++; errs++;
      end
      n_tests++;
      if (!$onehot0(bus.grant) || bus.grant_valid !== (|bus.grant)) begin
        $display("FAIL random_invariant c%0d: grant=%b valid=%b", c, bus.grant, bus.grant_valid);
        n_fail++; errs++;
      end
      for (int i = 0; i < N; i++) begin
        if (rst || !rq[i] || bus.grant[i]) waiting[i] = 0;
        else waiting[i]++;
        if (waiting[i] > BOUND) begin
          n_tests++;
          $display("FAIL starvation c%0d: requester %0d waited %0d, bound %0d",
                   c, i, waiting[i], BOUND);
          n_fail++; errs++;
          waiting[i] = 0;
        end
      end
    end
  endtask

  initial begin
    bus.request = '0;
    reset = 1'b1;
    test_reset();
    test_single_grant();
    test_rotation();
    test_quota_expiry();
    test_lone_owner();
    test_reset_mid_grant();
    test_random_stress();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
